// File: rtl/rca_4bit.sv
// rca_4bit: registered 4-bit ripple-carry adder built from four full-adder cells.
// Define RCA_4BIT_OVF_EN to add the registered signed-overflow output OVF.

module rca_4bit_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module rca_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Co,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] S,
    output logic       Cout
`ifdef RCA_4BIT_OVF_EN
    ,
    output logic       OVF
`endif
);

    logic [4:0] c;
    logic [3:0] s_c;

    assign c[0] = Co;

    // Carry ripples from cell i into cell i+1.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        rca_4bit_fa u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (s_c[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= 4'b0000;
            Cout <= 1'b0;
        end else begin
            S    <= s_c;
            Cout <= c[4];
        end
    end

`ifdef RCA_4BIT_OVF_EN
    logic ovf_c;

    // Like-signed operands producing an opposite-signed result.
    assign ovf_c = (A[3] == B[3]) && (s_c[3] != A[3]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OVF <= 1'b0;
        end else begin
            OVF <= ovf_c;
        end
    end
`endif

endmodule

// File: tb/tb_rca_4bit.sv
// tb_rca_4bit: scoreboard bench for rca_4bit (directed vectors, reset, full sweep).
// Expected results are queued at issue and checked one clock later by a monitor.

module tb_rca_4bit;

    logic       clk;
    logic       rst_n;
    logic       Co;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] S;
    logic       Cout;
`ifdef RCA_4BIT_OVF_EN
    logic       OVF;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [3:0] s;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    rca_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Co    (Co),
        .A     (A),
        .B     (B),
        .S     (S),
        .Cout  (Cout)
`ifdef RCA_4BIT_OVF_EN
        ,
        .OVF   (OVF)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input string nm, input logic [3:0] a,
                         input logic [3:0] b, input logic ci,
                         input logic [3:0] es, input logic ec,
                         input logic eo);
        exp_t e;
        @(negedge clk);
        A  = a;
        B  = b;
        Co = ci;
        e.name = nm;
        e.s    = es;
        e.cout = ec;
        e.ovf  = eo;
        sb.push_back(e);
    endtask

    task automatic chk_clear(input string nm);
        checks++;
        if (S !== 4'b0000 || Cout !== 1'b0) begin
            failures++;
            $display("FAIL %s: got S=%b Cout=%b want S=0000 Cout=0",
                     nm, S, Cout);
        end
`ifdef RCA_4BIT_OVF_EN
        checks++;
        if (OVF !== 1'b0) begin
            failures++;
            $display("FAIL %s_ovf: got OVF=%b want 0", nm, OVF);
        end
`endif
    endtask

    // Monitor: every rising edge presents a new result for a queued operation.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (S !== e.s || Cout !== e.cout) begin
                failures++;
                $display("FAIL %s: got S=%b Cout=%b want S=%b Cout=%b",
                         e.name, S, Cout, e.s, e.cout);
            end
`ifdef RCA_4BIT_OVF_EN
            checks++;
            if (OVF !== e.ovf) begin
                failures++;
                $display("FAIL %s_ovf: got OVF=%b want %b",
                         e.name, OVF, e.ovf);
            end
`endif
        end
    end

    initial begin
        logic [4:0] sum;
        logic       ov;
        int         wait_cyc;

        rst_n = 1'b0;
        A     = 4'($urandom);
        B     = 4'($urandom);
        Co    = 1'($urandom);
        #1;
        chk_clear("reset_t0");
        repeat (3) begin
            @(posedge clk);
            #2;
            A  = 4'($urandom);
            B  = 4'($urandom);
            Co = 1'($urandom);
        end
        chk_clear("reset_held");

        @(negedge clk);
        rst_n = 1'b1;
        issue("zero",      4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        issue("7p12",      4'b0111, 4'b1100, 1'b0, 4'b0011, 1'b1, 1'b0);
        issue("14p7",      4'b1110, 4'b0111, 1'b0, 4'b0101, 1'b1, 1'b0);
        issue("15p15",     4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0);
        issue("ripple",    4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
        issue("ovf_pos",   4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        issue("ovf_neg",   4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
        issue("5p2c",      4'b0101, 4'b0010, 1'b1, 4'b1000, 1'b0, 1'b1);
        issue("9p6",       4'b1001, 4'b0110, 1'b0, 4'b1111, 1'b0, 1'b0);

        // Inputs changing mid-cycle must not disturb the held result.
        issue("hold",      4'b0111, 4'b1100, 1'b0, 4'b0011, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        A  = 4'b1111;
        B  = 4'b1111;
        Co = 1'b1;
        #1;
        checks++;
        if (S !== 4'b0011 || Cout !== 1'b1) begin
            failures++;
            $display("FAIL hold_mid: got S=%b Cout=%b want S=0011 Cout=1",
                     S, Cout);
        end

        // Asynchronous reset mid-operation discards the pending result.
        issue("pre_rst",   4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0);
        @(negedge clk);
        A  = 4'b0111;
        B  = 4'b0001;
        Co = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_clear("async_clr");
        @(posedge clk);
        #1;
        chk_clear("rst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        issue("post_rst",  4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);

        // Full sweep of {Co,A,B}.
        for (int i = 0; i < 512; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       ci;
            ci  = i[8];
            a   = i[7:4];
            b   = i[3:0];
            sum = {1'b0, a} + {1'b0, b} + {4'b0, ci};
            ov  = (a[3] == b[3]) && (sum[3] != a[3]);
            issue($sformatf("sweep_%0d", i), a, b, ci, sum[3:0], sum[4], ov);
        end

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            #2;
            wait_cyc++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
